// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx into clk, recovers bytes with a one-cycle data_en strobe.
// Optional 8E1 framing with even-parity check when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_en,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LP_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LP_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_rx_s;
   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [2:0]             r_bit;
   logic [7:0]             r_shift;
   logic [7:0]             r_data;
   logic                   r_en;
   logic                   r_err;
   logic                   r_busy;
`ifdef UART_RX_PARITY_EN
   logic                   r_par;
`endif

   // Bring the asynchronous line into the clk domain; idle level is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      end
   end

   assign w_rx_s = r_sync[SYNC_STAGES-1];

   // Frame FSM; counter restarts on every state change so each wait is measured from entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_data  <= 8'h00;
         r_en    <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_en  <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               r_bit <= 3'd0;
               if (!w_rx_s) begin
                  r_state <= S_START;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (r_cnt == LP_HALF) begin
                  r_cnt <= '0;
                  if (!w_rx_s) begin
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
            S_DATA: begin
               if (r_cnt == LP_FULL) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rx_s, r_shift[7:1]};
                  if (r_bit == 3'd7) begin
                     r_bit <= 3'd0;
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit <= r_bit + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (r_cnt == LP_FULL) begin
                  r_cnt   <= '0;
                  r_par   <= w_rx_s;
                  r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
`endif
            S_STOP: begin
               if (r_cnt == LP_FULL) begin
                  r_cnt <= '0;
                  if (w_rx_s) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     // Parity failure still completes the frame, but reports an error instead of data.
                     if ((^{r_shift, r_par}) == 1'b0) begin
                        r_data <= r_shift;
                        r_en   <= 1'b1;
                     end else begin
                        r_err  <= 1'b1;
                     end
`else
                     r_data <= r_shift;
                     r_en   <= 1'b1;
`endif
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
            S_BREAK: begin
               r_cnt <= '0;
               if (w_rx_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = r_data;
   assign data_en   = r_en;
   assign frame_err = r_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are scheduled into an event queue with their expected
// outcome and strobe cycle, and one compare process checks every cycle against that model.
module tb_uart_rx;

   localparam int CPB = 8;
   localparam int NS  = 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB      = 10;
   localparam int LAT_LIT = 87;
`else
   localparam int NB      = 9;
   localparam int LAT_LIT = 79;
`endif
   localparam int LAT = NS + CPB / 2 + NB * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data_out;
   logic       data_en;
   logic       frame_err;
   logic       busy;

   uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(NS)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data_out  (data_out),
      .data_en   (data_en),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int   cyc   = 0;
   logic rst_q = 1'b1;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   typedef struct {
      int         t0;
      int         texp;
      bit         is_en;
      logic [7:0] d;
      bit         busy_low_after;
   } ev_t;

   ev_t        q[$];
   logic [7:0] last_good = 8'h00;
   int         vectors = 0, miscompares = 0;
   int         en_count = 0, err_count = 0, last_en_cyc = 0;
   bit         e_en, e_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Schedule the expected outcome of one frame, then drive it onto the line.
   task automatic send(input logic [7:0] d, input bit stop_v, input bit par_v, output int t0);
      ev_t ev;
      bit  ok;
      t0 = cyc;
      ok = stop_v;
`ifdef UART_RX_PARITY_EN
      ok = stop_v && ((^d) == par_v);
`endif
      ev.t0 = t0;
      ev.texp = t0 + LAT;
      ev.is_en = ok;
      ev.d = d;
      ev.busy_low_after = stop_v;
      q.push_back(ev);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      hold(par_v, CPB);
`endif
      hold(stop_v, CPB);
   endtask

   // Per-cycle comparison of all outputs against the event-queue model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_q) begin
            q.delete();
            last_good = 8'h00;
            check("rst_data_out", data_out, 8'h00);
            check("rst_data_en", data_en, 1'b0);
            check("rst_frame_err", frame_err, 1'b0);
            check("rst_busy", busy, 1'b0);
         end else begin
            e_en  = 1'b0;
            e_err = 1'b0;
            if (q.size() > 0) begin
               if (cyc >= q[0].t0 + NS + 1 && cyc < q[0].texp) check("busy_frame", busy, 1'b1);
               if (cyc == q[0].texp) begin
                  if (q[0].is_en) begin
                     e_en = 1'b1;
                     last_good = q[0].d;
                  end else begin
                     e_err = 1'b1;
                  end
                  if (q[0].busy_low_after) check("busy_end", busy, 1'b0);
                  void'(q.pop_front());
               end
            end
            check("data_en", data_en, e_en);
            check("frame_err", frame_err, e_err);
            check("data_out", data_out, last_good);
            if (data_en) begin
               en_count++;
               last_en_cyc = cyc;
            end
            if (frame_err) err_count++;
         end
      end
   end

   int         t0, e0, r0;
   logic [7:0] rd;
   bit         rstop, rpar;
   int         sel;

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      hold(1'b1, 2 * CPB);

      // single byte with literal latency
      e0 = en_count;
      send(8'h41, 1'b1, ^8'h41, t0);
      hold(1'b1, CPB);
      check("t1_count", en_count - e0, 1);
      check("t1_data", data_out, 8'h41);
      check("t1_latency", last_en_cyc - t0, LAT_LIT);

      // back-to-back frames
      e0 = en_count;
      r0 = err_count;
      send(8'h3E, 1'b1, ^8'h3E, t0);
      send(8'h30, 1'b1, ^8'h30, t0);
      hold(1'b1, CPB);
      check("b2b_count", en_count - e0, 2);
      check("b2b_err", err_count - r0, 0);
      check("b2b_data", data_out, 8'h30);

      // start-bit glitch
      e0 = en_count;
      r0 = err_count;
      hold(1'b0, 2);
      hold(1'b1, 2 * CPB);
      check("glitch_busy", busy, 1'b0);
      check("glitch_en", en_count - e0, 0);
      check("glitch_err", err_count - r0, 0);

      // bad stop bit, long break, recovery
      e0 = en_count;
      r0 = err_count;
      send(8'h55, 1'b0, ^8'h55, t0);
      hold(1'b0, 30 * CPB);
      check("break_data", data_out, 8'h30);
      check("break_busy", busy, 1'b1);
      hold(1'b1, 2);
      send(8'h0A, 1'b1, ^8'h0A, t0);
      hold(1'b1, CPB);
      check("break_err", err_count - r0, 1);
      check("break_en", en_count - e0, 1);
      check("break_data2", data_out, 8'h0A);

      // reset during the 4th data bit of 0xFF
      e0 = en_count;
      hold(1'b0, CPB);
      hold(1'b1, 3 * CPB + CPB / 2);
      rst = 1'b1;
      hold(1'b1, 3);
      check("rst_mid_data", data_out, 8'h00);
      check("rst_mid_busy", busy, 1'b0);
      rst = 1'b0;
      hold(1'b1, 2 * CPB);
      check("rst_no_strobe", en_count - e0, 0);
      send(8'h12, 1'b1, ^8'h12, t0);
      hold(1'b1, CPB);
      check("rst_en", en_count - e0, 1);
      check("rst_data", data_out, 8'h12);

`ifdef UART_RX_PARITY_EN
      e0 = en_count;
      r0 = err_count;
      send(8'h07, 1'b1, 1'b1, t0);
      hold(1'b1, CPB);
      check("par_ok_en", en_count - e0, 1);
      check("par_ok_data", data_out, 8'h07);
      send(8'h07, 1'b1, 1'b0, t0);
      hold(1'b1, CPB);
      check("par_bad_err", err_count - r0, 1);
      check("par_bad_data", data_out, 8'h07);
`endif

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) begin
            hold(1'b0, $urandom_range(1, CPB / 2 - 1));
            hold(1'b1, CPB);
         end
         rd    = 8'($urandom);
         rstop = (sel != 1);
         rpar  = ^rd;
`ifdef UART_RX_PARITY_EN
         if (sel == 2) rpar = ~rpar;
`endif
         send(rd, rstop, rpar, t0);
         if (!rstop) begin
            hold(1'b0, $urandom_range(1, 3 * CPB));
            hold(1'b1, $urandom_range(1, 2 * CPB));
         end else if ($urandom_range(0, 1) == 1) begin
            hold(1'b1, $urandom_range(1, 3 * CPB));
         end
      end

      hold(1'b1, 2 * CPB);
      check("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
